// File: rtl/line_buf_pkg.sv
// -----------------------------------------------------------------------------
// line_buf_pkg
// Shared types and helpers for the line_buf_vscaler block.
//   state_t     : 3-bit FSM state encoding, with ST_* constants
//   mode_t      : runtime vertical-processing mode
//   decode_mode : maps the raw 2-bit mode input onto mode_t (reserved -> DELAY)
//   avg_round   : per-channel round-half-up average, computed one bit wider
//                 than the operands so the carry is never lost
// -----------------------------------------------------------------------------
package line_buf_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE       = 3'd0;
   localparam state_t ST_WAIT_DE    = 3'd1;
   localparam state_t ST_ACT_FIRST  = 3'd2;
   localparam state_t ST_ACT_MID    = 3'd3;
   localparam state_t ST_WAIT_FLUSH = 3'd4;
   localparam state_t ST_ACT_LAST   = 3'd5;

   typedef enum logic [1:0] {
      MODE_DELAY = 2'd0,
      MODE_AVG   = 2'd1,
      MODE_DEC   = 2'd2
   } mode_t;

   // Widest channel the average helper supports; callers zero-extend into it.
   localparam int AVG_W = 16;

   function automatic mode_t decode_mode(input logic [1:0] raw);
      mode_t m;
      case (raw)
         2'd1:    m = MODE_AVG;
         2'd2:    m = MODE_DEC;
         default: m = MODE_DELAY;
      endcase
      return m;
   endfunction

   // (a + b + 1) >> 1 at AVG_W+1 bits. For two DW-bit operands the result
   // always fits back into DW bits, so the caller may truncate safely.
   function automatic logic [AVG_W-1:0] avg_round(input logic [AVG_W-1:0] a,
                                                  input logic [AVG_W-1:0] b);
      logic [AVG_W:0] sum;
      sum = {1'b0, a} + {1'b0, b} + {{AVG_W{1'b0}}, 1'b1};
      return AVG_W'(sum >> 1);
   endfunction

endpackage

// File: rtl/single_port_ram.sv
// -----------------------------------------------------------------------------
// single_port_ram
// One-port synchronous RAM, read-first, 1-clk read latency.
//   clk    : clock
//   i_we   : write enable
//   i_addr : address (read and write)
//   i_din  : write data
//   o_dout : registered read data of i_addr from the previous cycle
// Storage and the read register carry no reset; contents are only meaningful
// after they have been written.
// -----------------------------------------------------------------------------
module single_port_ram #(
   parameter int AW = 6,
   parameter int DW = 30
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_din,
   output logic [DW-1:0] o_dout
);

   logic [DW-1:0] r_mem [0:(1<<AW)-1];

   // Write port and registered read port.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_din;
      end
      o_dout <= r_mem[i_addr];
   end

endmodule

// File: rtl/line_buf_vscaler.sv
// -----------------------------------------------------------------------------
// line_buf_vscaler
// Two-line ping-pong line buffer with a vertical stage: one-line delay with
// last-line flush, 2:1 vertical average, or 2:1 vertical decimation.
//   clk, rst   : clock, synchronous active-high reset
//   i_vsync    : frame sync (active low, frame starts on its falling edge)
//   i_hsync    : line sync (active low)
//   i_de       : input pixel valid
//   i_data     : input pixel, channel 0 in the MSBs
//   i_mode     : 0 DELAY, 1 AVG, 2 DEC, 3 treated as DELAY
//   i_hact     : active pixels per line (1..H_MAX)
//   i_vact     : active lines per frame (>=2)
//   o_vsync    : i_vsync delayed 1 clk
//   o_hsync    : i_hsync delayed 1 clk
//   o_de       : output pixel valid
//   o_data     : output pixel, 0 when o_de is low
//   o_ovf      : sticky line-overflow flag, cleared at frame start
// -----------------------------------------------------------------------------
module line_buf_vscaler
   import line_buf_pkg::*;
#(
   parameter int DW    = 10,
   parameter int NCH   = 3,
   parameter int H_MAX = 64,
   parameter int VW    = 11
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_vsync,
   input  logic                     i_hsync,
   input  logic                     i_de,
   input  logic [DW*NCH-1:0]        i_data,
   input  logic [1:0]               i_mode,
   input  logic [$clog2(H_MAX):0]   i_hact,
   input  logic [VW-1:0]            i_vact,
   output logic                     o_vsync,
   output logic                     o_hsync,
   output logic                     o_de,
   output logic [DW*NCH-1:0]        o_data,
   output logic                     o_ovf
);

   localparam int AW = $clog2(H_MAX);
   localparam int PW = DW * NCH;
   localparam logic [AW:0]   H_LIM  = (AW+1)'(H_MAX);
   localparam logic [AW:0]   H_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   H_ZERO = {(AW+1){1'b0}};
   localparam logic [AW:0]   H_SAT  = {(AW+1){1'b1}};
   localparam logic [VW-1:0] V_ONE  = {{(VW-1){1'b0}}, 1'b1};
   localparam logic [VW-1:0] V_ZERO = {VW{1'b0}};

   // Registered copies of the syncs and de; also the 1-clk sync outputs.
   logic          r_vs_q, r_hs_q, r_de_q;
   logic [PW-1:0] r_pix;

   // Per-frame shadows.
   mode_t         r_mode;
   logic [AW:0]   r_hact;
   logic [VW-1:0] r_vact;

   // FSM and counters.
   state_t        r_state, w_state_nxt;
   logic [VW-1:0] r_v_cnt;
   logic [AW:0]   r_h_cnt;
   logic [AW:0]   r_f_cnt;
   logic [AW:0]   r_wlen;

   // Output-stage registers.
   logic          r_de_o;
   logic          r_rd_sel;
   logic          r_out_avg;
   logic          r_ovf;

   // Combinational decode.
   logic          w_vs_fall, w_hs_fall, w_de_fall;
   logic [AW:0]   w_h_lim;
   logic          w_in_act, w_in_line, w_in_flush;
   logic          w_take, w_in_range, w_wr, w_line_out;
   logic          w_flush_rd, w_rd_vld, w_ovf_set;
   logic          w_we0, w_we1;
   logic [AW-1:0] w_addr;
   logic [PW-1:0] w_dout0, w_dout1, w_dout, w_avg;

   assign w_vs_fall = r_vs_q & ~i_vsync;
   assign w_hs_fall = r_hs_q & ~i_hsync;
   assign w_de_fall = r_de_q & ~i_de;

   // Effective line length: a pixel is stored only below both hact and H_MAX.
   assign w_h_lim = (r_hact < H_LIM) ? r_hact : H_LIM;

   // Pixel acceptance, RAM write/read strobes and overflow detection.
   always_comb begin
      w_in_act   = (r_state == ST_ACT_FIRST) || (r_state == ST_ACT_MID);
      w_in_line  = w_in_act || ((r_state == ST_WAIT_DE) && (r_v_cnt != r_vact));
      w_in_flush = (r_state == ST_WAIT_FLUSH) || (r_state == ST_ACT_LAST);
      w_take     = i_de && w_in_line && !w_vs_fall;
      w_in_range = (r_h_cnt < w_h_lim);
      w_wr       = w_take && w_in_range;
      case (r_mode)
         MODE_DELAY: w_line_out = (r_v_cnt != V_ZERO);
         MODE_AVG:   w_line_out = r_v_cnt[0];
         MODE_DEC:   w_line_out = r_v_cnt[0];
         default:    w_line_out = 1'b0;
      endcase
      // The first flush read goes out in the same cycle the hsync edge is seen.
      w_flush_rd = !w_vs_fall &&
                   (((r_state == ST_WAIT_FLUSH) && w_hs_fall) || (r_state == ST_ACT_LAST));
      w_rd_vld   = (w_wr && w_line_out) || w_flush_rd;
      if (w_in_flush) begin
         w_addr = r_f_cnt[AW-1:0];
      end else begin
         w_addr = r_h_cnt[AW-1:0];
      end
      w_we0     = w_wr && !r_v_cnt[0];
      w_we1     = w_wr &&  r_v_cnt[0];
      w_ovf_set = (w_take && !w_in_range) || (i_de && w_in_flush && !w_vs_fall);
   end

   // Next-state logic; a vsync falling edge restarts the frame from any state.
   always_comb begin
      w_state_nxt = r_state;
      if (w_vs_fall) begin
         w_state_nxt = ST_WAIT_DE;
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = ST_IDLE;
            ST_WAIT_DE: begin
               if (r_v_cnt == r_vact) begin
                  if (r_mode == MODE_DELAY) begin
                     w_state_nxt = ST_WAIT_FLUSH;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else if (i_de) begin
                  if (r_v_cnt == V_ZERO) begin
                     w_state_nxt = ST_ACT_FIRST;
                  end else begin
                     w_state_nxt = ST_ACT_MID;
                  end
               end else begin
                  w_state_nxt = ST_WAIT_DE;
               end
            end
            ST_ACT_FIRST, ST_ACT_MID: begin
               if (w_de_fall) begin
                  w_state_nxt = ST_WAIT_DE;
               end else begin
                  w_state_nxt = r_state;
               end
            end
            ST_WAIT_FLUSH: begin
               if (!w_hs_fall) begin
                  w_state_nxt = ST_WAIT_FLUSH;
               end else if (r_wlen <= H_ONE) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_ACT_LAST;
               end
            end
            ST_ACT_LAST: begin
               if ((r_f_cnt + H_ONE) >= r_wlen) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_ACT_LAST;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Sync/de edge-detect registers and the input pixel pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vs_q <= 1'b1;
         r_hs_q <= 1'b1;
         r_de_q <= 1'b0;
         r_pix  <= {PW{1'b0}};
      end else begin
         r_vs_q <= i_vsync;
         r_hs_q <= i_hsync;
         r_de_q <= i_de;
         r_pix  <= i_data;
      end
   end

   // Frame shadow registers, captured once per frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode <= MODE_DELAY;
         r_hact <= H_ZERO;
         r_vact <= V_ZERO;
      end else if (w_vs_fall) begin
         r_mode <= decode_mode(i_mode);
         r_hact <= i_hact;
         r_vact <= i_vact;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Line, pixel and flush counters plus the stored length of the last line.
   always_ff @(posedge clk) begin
      if (rst || w_vs_fall) begin
         r_v_cnt <= V_ZERO;
         r_h_cnt <= H_ZERO;
         r_f_cnt <= H_ZERO;
         r_wlen  <= H_ZERO;
      end else begin
         if (w_de_fall && w_in_act) begin
            r_v_cnt <= r_v_cnt + V_ONE;
            r_wlen  <= (r_h_cnt < w_h_lim) ? r_h_cnt : w_h_lim;
         end
         if (w_de_fall) begin
            r_h_cnt <= H_ZERO;
         end else if (w_take && (r_h_cnt != H_SAT)) begin
            r_h_cnt <= r_h_cnt + H_ONE;
         end
         if (r_state == ST_ACT_LAST) begin
            r_f_cnt <= r_f_cnt + H_ONE;
         end else if ((r_state == ST_WAIT_FLUSH) && w_hs_fall) begin
            r_f_cnt <= H_ONE;
         end else begin
            r_f_cnt <= H_ZERO;
         end
      end
   end

   // Output-stage registers: valid, read-bank select, average enable, overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_de_o    <= 1'b0;
         r_rd_sel  <= 1'b0;
         r_out_avg <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_de_o    <= w_rd_vld;
         r_rd_sel  <= ~r_v_cnt[0];
         r_out_avg <= (r_mode == MODE_AVG);
         if (w_vs_fall) begin
            r_ovf <= 1'b0;
         end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end
      end
   end

   // Bank 0 holds even lines, bank 1 odd lines; the idle bank is the one read.
   single_port_ram #(.AW(AW), .DW(PW)) u_ram0 (
      .clk    (clk),
      .i_we   (w_we0),
      .i_addr (w_addr),
      .i_din  (i_data),
      .o_dout (w_dout0)
   );

   single_port_ram #(.AW(AW), .DW(PW)) u_ram1 (
      .clk    (clk),
      .i_we   (w_we1),
      .i_addr (w_addr),
      .i_din  (i_data),
      .o_dout (w_dout1)
   );

   // Output pixel: the RAM read register and the piped input pixel arrive
   // together one clk after the read, so the mux/average sits after them.
   always_comb begin
      if (r_rd_sel) begin
         w_dout = w_dout1;
      end else begin
         w_dout = w_dout0;
      end
      w_avg = {PW{1'b0}};
      for (int c = 0; c < NCH; c++) begin
         w_avg[c*DW +: DW] = DW'(avg_round(AVG_W'(w_dout[c*DW +: DW]),
                                           AVG_W'(r_pix[c*DW +: DW])));
      end
      if (!r_de_o) begin
         o_data = {PW{1'b0}};
      end else if (r_out_avg) begin
         o_data = w_avg;
      end else begin
         o_data = w_dout;
      end
   end

   assign o_vsync = r_vs_q;
   assign o_hsync = r_hs_q;
   assign o_de    = r_de_o;
   assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_line_buf_vscaler.sv
// Scoreboard bench for line_buf_vscaler: stimulus tasks push the expected
// output pixels, an independent negedge monitor pops and compares them.
module tb_line_buf_vscaler;
   import line_buf_pkg::*;

   localparam int DW = 10;
   localparam int NCH = 3;
   localparam int PW = DW * NCH;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_vsync, i_hsync, i_de;
   logic [PW-1:0] i_data;
   logic [1:0]    i_mode;
   logic [6:0]    i_hact;
   logic [10:0]   i_vact;
   logic          o_vsync, o_hsync, o_de, o_ovf;
   logic [PW-1:0] o_data;

   int            n_cmp = 0;
   int            n_err = 0;
   bit            mon_en = 1'b0;
   logic [PW-1:0] exp_q [$];

   line_buf_vscaler #(.DW(DW), .NCH(NCH), .H_MAX(64), .VW(11)) dut (
      .clk(clk), .rst(rst), .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
      .i_data(i_data), .i_mode(i_mode), .i_hact(i_hact), .i_vact(i_vact),
      .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de), .o_data(o_data), .o_ovf(o_ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] pat(input int l, input int x);
      return {10'(l), 10'(x), 10'(l * 16 + x + 5)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every o_de pixel must match the head of the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         if (o_de) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_o_de: got o_data=%0h, required no output", o_data);
            end else begin
               chk("o_data", o_data, exp_q.pop_front());
            end
         end else begin
            chk("o_data_idle_zero", o_data, 0);
         end
      end
   end

   task automatic frame_start(input int mode, input int hact, input int vact);
      i_mode = 2'(mode);
      i_hact = 7'(hact);
      i_vact = 11'(vact);
      i_vsync = 1'b0;
      tick(); tick();
      i_vsync = 1'b1;
      tick(); tick();
   endtask

   task automatic line_head();
      i_hsync = 1'b0;
      tick(); tick();
      i_hsync = 1'b1;
      tick(); tick();
   endtask

   task automatic pix(input logic [PW-1:0] d, input bit do_push, input logic [PW-1:0] e);
      i_de = 1'b1;
      i_data = d;
      if (do_push) exp_q.push_back(e);
      tick();
   endtask

   // kind: 0 no output expected, 1 previous pattern line, 2 fixed value
   task automatic send_line(input int ln, input int npix, input int kind, input int n_exp,
                            input bit use_fixed, input logic [PW-1:0] fin,
                            input logic [PW-1:0] fexp);
      line_head();
      for (int x = 0; x < npix; x++) begin
         pix(use_fixed ? fin : pat(ln, x), (kind != 0) && (x < n_exp),
             (kind == 1) ? pat(ln - 1, x) : fexp);
      end
      i_de = 1'b0;
      i_data = '0;
      tick(); tick(); tick();
   endtask

   task automatic flush(input int ln, input int n);
      for (int x = 0; x < n; x++) begin
         i_hsync = (x == 0) ? 1'b0 : 1'b1;
         exp_q.push_back(pat(ln, x));
         tick();
         if (x == 0) begin
            @(negedge clk);
            chk("flush_first_o_de", o_de, 1);
         end
      end
      i_hsync = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; i_vsync = 1'b1; i_hsync = 1'b1; i_de = 1'b0; i_data = '0;
      i_mode = 2'd0; i_hact = 7'd10; i_vact = 11'd4;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_o_de", o_de, 0);
      chk("rst_o_data", o_data, 0);
      chk("rst_o_vsync", o_vsync, 1);
      chk("rst_o_hsync", o_hsync, 1);
      chk("rst_o_ovf", o_ovf, 0);
      rst = 1'b0;
      mon_en = 1'b1;
      tick();

      // DELAY, hact=10, vact=4, with last-line flush
      frame_start(0, 10, 4);
      for (int ln = 0; ln < 4; ln++) send_line(ln, 10, (ln == 0) ? 0 : 1, 10, 1'b0, '0, '0);
      flush(3, 10);
      chk("delay_idle", dut.r_state, ST_IDLE);

      // DEC, hact=8, vact=5: lines 0 and 2 out, line 4 dropped, no flush
      frame_start(2, 8, 5);
      for (int ln = 0; ln < 5; ln++) send_line(ln, 8, ln % 2, 8, 1'b0, '0, '0);
      i_hsync = 1'b0; tick(); i_hsync = 1'b1;
      repeat (12) tick();
      chk("dec_idle", dut.r_state, ST_IDLE);

      // Overflow: 12 pixels on line 1 with hact=10
      frame_start(0, 10, 3);
      send_line(0, 10, 0, 10, 1'b0, '0, '0);
      chk("ovf_before", o_ovf, 0);
      line_head();
      for (int x = 0; x < 12; x++) begin
         pix(pat(1, x), x < 10, pat(0, x));
         @(negedge clk);
         chk("ovf_during", o_ovf, (x >= 10) ? 1 : 0);
      end
      i_de = 1'b0; i_data = '0;
      tick(); tick(); tick();
      send_line(2, 10, 1, 10, 1'b0, '0, '0);
      chk("ovf_sticky", o_ovf, 1);
      flush(2, 10);
      chk("ovf_sticky_end", o_ovf, 1);

      // Reset during line 2, then a clean frame
      frame_start(0, 10, 4);
      chk("ovf_cleared", o_ovf, 0);
      send_line(0, 10, 0, 10, 1'b0, '0, '0);
      send_line(1, 10, 1, 10, 1'b0, '0, '0);
      line_head();
      for (int x = 0; x < 4; x++) pix(pat(2, x), 1'b1, pat(1, x));
      rst = 1'b1;
      i_data = pat(2, 4);
      tick();
      @(negedge clk);
      chk("mid_rst_o_de", o_de, 0);
      chk("mid_rst_o_data", o_data, 0);
      chk("mid_rst_o_vsync", o_vsync, 1);
      chk("mid_rst_o_hsync", o_hsync, 1);
      rst = 1'b0; i_de = 1'b0; i_data = '0;
      repeat (3) tick();
      frame_start(0, 10, 4);
      for (int ln = 0; ln < 4; ln++) send_line(ln, 10, (ln == 0) ? 0 : 1, 10, 1'b0, '0, '0);
      flush(3, 10);

      // vsync falls during the flush; new frame latches AVG
      frame_start(0, 10, 2);
      send_line(0, 10, 0, 10, 1'b0, '0, '0);
      send_line(1, 10, 1, 10, 1'b0, '0, '0);
      i_hsync = 1'b0; exp_q.push_back(pat(1, 0)); tick();
      i_hsync = 1'b1; exp_q.push_back(pat(1, 1)); tick();
      exp_q.push_back(pat(1, 2)); tick();
      i_vsync = 1'b0; i_mode = 2'd1; i_vact = 11'd4;
      tick();
      @(negedge clk);
      chk("abort_o_de", o_de, 0);
      chk("abort_state", dut.r_state, ST_WAIT_DE);
      chk("abort_mode", dut.r_mode, MODE_AVG);
      tick();
      i_vsync = 1'b1;
      tick(); tick();

      // AVG, hact=10, vact=4: outputs 151 and 512 on every channel
      send_line(0, 10, 0, 10, 1'b1, {3{10'd100}}, '0);
      send_line(1, 10, 2, 10, 1'b1, {3{10'd201}}, {3{10'd151}});
      send_line(2, 10, 0, 10, 1'b1, {3{10'd0}}, '0);
      send_line(3, 10, 2, 10, 1'b1, {3{10'd1023}}, {3{10'd512}});
      i_hsync = 1'b0; tick(); i_hsync = 1'b1;
      repeat (6) tick();
      chk("avg_idle", dut.r_state, ST_IDLE);
      chk("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
